hazard_scheduler: RTL

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_scheduler.sv
// Batch hazard scheduler: loads eight instruction bytes, then walks every
// (older, younger) pair inside WINDOW through one comparator and reports RAW/WAR/WAW results.
module hazard_scheduler #(
  parameter int WINDOW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr_in,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] hazard_reg,
  output logic [2:0] hazard_type,
  output logic [3:0] hazard_cnt,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in LOAD.
  state_t state, state_nxt;

  logic [5:0] mem [8];
  logic [2:0] idx;
  logic [2:0] cj;
  logic [1:0] cd;
  logic [7:0] wreg;
  logic [2:0] wtype;
  logic [3:0] wcnt;

  logic       unused_op_bits;
  logic [5:0] older, younger;
  logic       raw, war, waw, hit;
  logic [1:0] d_max;
  logic       pair_last_d, last_cmp;
  logic [7:0] wreg_upd;
  logic [2:0] wtype_upd;
  logic [3:0] wcnt_upd;

  // The op field plays no part in hazard detection.
  assign unused_op_bits = ^instr_in[7:6];

  assign older   = mem[cj - 3'(cd)];
  assign younger = mem[cj];

  assign raw = (older[5:4] == younger[3:2]) || (older[5:4] == younger[1:0]);
  assign war = (younger[5:4] == older[3:2]) || (younger[5:4] == older[1:0]);
  assign waw = (older[5:4] == younger[5:4]);
  assign hit = raw | war | waw;

  // Instruction 1 has only one older neighbour, whatever the window.
  assign d_max       = (WINDOW == 1 || cj == 3'd1) ? 2'd1 : 2'd2;
  assign pair_last_d = (cd == d_max);
  assign last_cmp    = (cj == 3'd7) && pair_last_d;

  assign wreg_upd  = wreg | ({7'd0, hit} << cj);
  assign wtype_upd = wtype | (hit ? {raw, war, waw} : 3'b000);
  assign wcnt_upd  = wcnt + {3'd0, hit};

  assign instr_ready = (state == LOAD);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (instr_valid && idx == 3'd7) state_nxt = CHECK;
      CHECK:   if (last_cmp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) mem[k] <= '0;
      idx         <= '0;
      cj          <= 3'd1;
      cd          <= 2'd1;
      wreg        <= '0;
      wtype       <= '0;
      wcnt        <= '0;
      hazard_reg  <= '0;
      hazard_type <= '0;
      hazard_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            cj    <= 3'd1;
            cd    <= 2'd1;
            wreg  <= '0;
            wtype <= '0;
            wcnt  <= '0;
          end
        end
        LOAD: begin
          if (instr_valid) begin
            mem[idx] <= instr_in[5:0];
            idx      <= idx + 3'd1;
          end
        end
        CHECK: begin
          wreg  <= wreg_upd;
          wtype <= wtype_upd;
          wcnt  <= wcnt_upd;
          if (pair_last_d) begin
            cj <= cj + 3'd1;
            cd <= 2'd1;
          end else begin
            cd <= cd + 2'd1;
          end
          // Publish including the final pair's contribution.
          if (last_cmp) begin
            hazard_reg  <= wreg_upd;
            hazard_type <= wtype_upd;
            hazard_cnt  <= wcnt_upd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
